hazard_control: RTL and testbench

- Hazard and forwarding controller that sequences the instruction-decode stage.
- Tracks the destination registers of the three instructions ahead of decode (execute, memory, writeback) in a 3-slot shift scoreboard.
- Drives the decode stage's rs1/rs2 forwarding selects.
- Inserts bubbles (stall) on load-use hazards and on flushes.

---
 rtl/core_pkg.sv | 36 +++
 rtl/hazard_match.sv | 40 ++++
 rtl/hazard_control.sv | 109 ++++++++++
 tb/tb_hazard_control.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types for the decode hazard/forwarding controller
//
// Purpose : register address type, forward-select encoding, scoreboard entry
//           and the slot-to-select mapping used by hazard_match.
// Contents: SB_DEPTH, addr_t, rs_t, sb_entry_t, slot_sel().
package core;

  // Slots tracked ahead of decode: execute, memory, writeback.
  localparam int SB_DEPTH = 3;

  typedef logic [4:0] addr_t;

  // REG is the register-file read path (no forwarding).
  typedef enum logic [1:0] {
    REG = 2'd0,
    ALU = 2'd1,
    EXE = 2'd2,
    MEM = 2'd3
  } rs_t;

  typedef struct packed {
    logic  vld;
    addr_t rd;
    logic  ld;
  } sb_entry_t;

  // Index 0 is slot1 (execute), which forwards alu_data; deeper slots follow.
  function automatic rs_t slot_sel(input int k);
    case (k)
      0:       return ALU;
      1:       return EXE;
      default: return MEM;
    endcase
  endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - per-source-register forward select and load-use hazard
//
// Purpose : finds the nearest scoreboard slot writing the source register and
//           turns it into a forward select, or a hazard when that slot is a
//           load whose data is not yet available.
// Ports   : slots_i  scoreboard, index 0 = slot1 (nearest)
//           rs_i     source register address
//           uses_i   instruction actually reads rs_i
//           sel_o    forward select (REG when no match or on hazard)
//           hazard_o winning slot is a load younger than LOAD_FWD_SLOT
module hazard_match
  import core::*;
#(
  parameter int LOAD_FWD_SLOT = 3
) (
  input  sb_entry_t [SB_DEPTH-1:0] slots_i,
  input  addr_t                    rs_i,
  input  logic                     uses_i,
  output rs_t                      sel_o,
  output logic                     hazard_o
);

  // Walk from the farthest slot to the nearest so the nearest match overrides.
  always_comb begin
    sel_o    = REG;
    hazard_o = 1'b0;
    for (int k = SB_DEPTH - 1; k >= 0; k--) begin
      if (uses_i && (rs_i != '0) && slots_i[k].vld && (slots_i[k].rd == rs_i)) begin
        if (slots_i[k].ld && ((k + 1) < LOAD_FWD_SLOT)) begin
          sel_o    = REG;
          hazard_o = 1'b1;
        end else begin
          sel_o    = slot_sel(k);
          hazard_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_control.sv
// rtl/hazard_control.sv - decode-stage hazard and forwarding controller
//
// Purpose : 3-slot shift scoreboard of destination registers ahead of decode;
//           drives rs1/rs2 forward selects and stalls decode on load-use.
// Ports   : aclk, aresetn (sync, active low), pipe_ready (scoreboard advance),
//           id_* decoded instruction fields, flush (kill decode),
//           rs1_sel/rs2_sel forward selects, stall (hold decode, bubble out).
// Option  : HAZARD_STATS_EN adds stall_cycles and fwd_events counters.
module hazard_control
  import core::*;
#(
  parameter int LOAD_FWD_SLOT = 3,
  parameter int CNT_W         = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             pipe_ready,
  input  logic             id_valid,
  input  addr_t            id_rs1,
  input  addr_t            id_rs2,
  input  addr_t            id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_writes_rd,
  input  logic             id_is_load,
  input  logic             flush,
  output rs_t              rs1_sel,
  output rs_t              rs2_sel,
  output logic             stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] fwd_events
`endif
);

  sb_entry_t [SB_DEPTH-1:0] sb_q, sb_d;
  logic                     hz_rs1, hz_rs2;

  hazard_match #(.LOAD_FWD_SLOT(LOAD_FWD_SLOT)) u_match_rs1 (
    .slots_i (sb_q),
    .rs_i    (id_rs1),
    .uses_i  (id_uses_rs1),
    .sel_o   (rs1_sel),
    .hazard_o(hz_rs1)
  );

  hazard_match #(.LOAD_FWD_SLOT(LOAD_FWD_SLOT)) u_match_rs2 (
    .slots_i (sb_q),
    .rs_i    (id_rs2),
    .uses_i  (id_uses_rs2),
    .sel_o   (rs2_sel),
    .hazard_o(hz_rs2)
  );

  // A flush kills the decode instruction, so it never waits on a hazard.
  assign stall = id_valid & ~flush & (hz_rs1 | hz_rs2);

  // Stalled or flushed decode enters slot1 as a bubble; x0 writes never track.
  always_comb begin
    sb_d = sb_q;
    if (pipe_ready) begin
      for (int k = SB_DEPTH - 1; k >= 1; k--) begin
        sb_d[k] = sb_q[k-1];
      end
      sb_d[0].vld = id_valid & ~stall & ~flush & id_writes_rd & (id_rd != '0);
      sb_d[0].rd  = id_rd;
      sb_d[0].ld  = id_is_load;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] fwd_events_q, fwd_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    fwd_events_d   = fwd_events_q;
    if (stall && pipe_ready) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (id_valid && !stall && pipe_ready && ((rs1_sel != REG) || (rs2_sel != REG))) begin
      fwd_events_d = fwd_events_q + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_events_q   <= fwd_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_events   = fwd_events_q;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// tb/tb_hazard_control.sv - directed self-checking bench for hazard_control
module tb_hazard_control;
  import core::*;

  localparam int CNT_W = 32;

  logic  aclk = 1'b0;
  logic  aresetn;
  logic  pipe_ready;
  logic  id_valid;
  addr_t id_rs1, id_rs2, id_rd;
  logic  id_uses_rs1, id_uses_rs2, id_writes_rd, id_is_load;
  logic  flush;
  rs_t   rs1_sel, rs2_sel, rs1_sel2, rs2_sel2;
  logic  stall, stall2;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cycles, fwd_events, stall_cycles2, fwd_events2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  hazard_control #(.LOAD_FWD_SLOT(3), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .pipe_ready(pipe_ready), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_writes_rd(id_writes_rd), .id_is_load(id_is_load), .flush(flush),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .stall(stall)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .fwd_events(fwd_events)
`endif
  );

  hazard_control #(.LOAD_FWD_SLOT(2), .CNT_W(CNT_W)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .pipe_ready(pipe_ready), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_writes_rd(id_writes_rd), .id_is_load(id_is_load), .flush(flush),
    .rs1_sel(rs1_sel2), .rs2_sel(rs2_sel2), .stall(stall2)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles2), .fwd_events(fwd_events2)
`endif
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Drive one decoded instruction; outputs are sampled 1 time unit later.
  task automatic drv(input logic v, input int rs1, input int rs2, input int rd,
                     input logic u1, input logic u2, input logic wr, input logic ld);
    id_valid     = v;
    id_rs1       = addr_t'(rs1);
    id_rs2       = addr_t'(rs2);
    id_rd        = addr_t'(rd);
    id_uses_rs1  = u1;
    id_uses_rs2  = u2;
    id_writes_rd = wr;
    id_is_load   = ld;
    flush        = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    drv(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    pipe_ready = 1'b1;
    drv(1'b1, 5, 5, 6, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    aresetn = 1'b1;
    drv(1'b1, 5, 5, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (rs1_sel !== REG) begin bad++; $display("FAIL reset_rs1: got %0d want %0d", rs1_sel, REG); end
    total++; if (rs2_sel !== REG) begin bad++; $display("FAIL reset_rs2: got %0d want %0d", rs2_sel, REG); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
    idle(1);
  endtask

  task automatic test_alu_forward();
    drv(1'b1, 0, 0, 5, 1'b1, 1'b0, 1'b1, 1'b0);      // addi x5,x0,1
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL addi_stall: got %0b want 0", stall); end
    tick();
    drv(1'b1, 5, 5, 6, 1'b1, 1'b1, 1'b1, 1'b0);      // add x6,x5,x5
    total++; if (rs1_sel !== ALU) begin bad++; $display("FAIL alu_rs1: got %0d want %0d", rs1_sel, ALU); end
    total++; if (rs2_sel !== ALU) begin bad++; $display("FAIL alu_rs2: got %0d want %0d", rs2_sel, ALU); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %0b want 0", stall); end
    tick();
    drv(1'b1, 5, 0, 7, 1'b1, 1'b1, 1'b1, 1'b0);      // sub x7,x5,x0
    total++; if (rs1_sel !== EXE) begin bad++; $display("FAIL exe_rs1: got %0d want %0d", rs1_sel, EXE); end
    total++; if (rs2_sel !== REG) begin bad++; $display("FAIL exe_rs2_x0: got %0d want %0d", rs2_sel, REG); end
    tick();
    idle(4);
  endtask

  task automatic test_load_use();
    drv(1'b1, 1, 0, 5, 1'b1, 1'b0, 1'b1, 1'b1);      // lw x5,0(x1)
    tick();
    drv(1'b1, 5, 0, 6, 1'b1, 1'b1, 1'b1, 1'b0);      // add x6,x5,x0
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall1: got %0b want 1", stall); end
    tick();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall2: got %0b want 1", stall); end
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_release: got %0b want 0", stall); end
    total++; if (rs1_sel !== MEM) begin bad++; $display("FAIL lu_mem_rs1: got %0d want %0d", rs1_sel, MEM); end
    tick();
    // add x6 now in slot1; the load has left the scoreboard
    drv(1'b1, 6, 5, 9, 1'b1, 1'b1, 1'b1, 1'b0);
    total++; if (rs1_sel !== ALU) begin bad++; $display("FAIL lu_after_rs1: got %0d want %0d", rs1_sel, ALU); end
    total++; if (rs2_sel !== REG) begin bad++; $display("FAIL lu_after_rs2: got %0d want %0d", rs2_sel, REG); end
    total++; if (dut.sb_q[1].vld !== 1'b0 || dut.sb_q[2].vld !== 1'b0) begin
      bad++; $display("FAIL lu_bubbles: got vld2=%0b vld3=%0b want 0 0", dut.sb_q[1].vld, dut.sb_q[2].vld);
    end
    idle(4);
  endtask

  task automatic test_reorder();
    drv(1'b1, 0, 0, 5, 1'b1, 1'b0, 1'b1, 1'b0);      // addi x5
    tick();
    drv(1'b1, 1, 0, 5, 1'b1, 1'b0, 1'b1, 1'b1);      // lw x5
    tick();
    drv(1'b1, 5, 0, 6, 1'b1, 1'b0, 1'b1, 1'b0);      // reader of x5
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL ro_stall_s1: got %0b want 1", stall); end
    total++; if (stall2 !== 1'b1) begin bad++; $display("FAIL ro_stall2_s1: got %0b want 1", stall2); end
    tick();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL ro_stall_s2: got %0b want 1", stall); end
    total++; if (stall2 !== 1'b0) begin bad++; $display("FAIL ro_stall2_s2: got %0b want 0", stall2); end
    total++; if (rs1_sel2 !== EXE) begin bad++; $display("FAIL ro_exe2: got %0d want %0d", rs1_sel2, EXE); end
    tick();
    idle(4);
  endtask

  task automatic test_x0_and_invalid();
    drv(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);      // write to x0
    tick();
    drv(1'b1, 0, 0, 8, 1'b1, 1'b1, 1'b1, 1'b0);      // read x0
    total++; if (dut.sb_q[0].vld !== 1'b0) begin bad++; $display("FAIL x0_vld: got %0b want 0", dut.sb_q[0].vld); end
    total++; if (rs1_sel !== REG) begin bad++; $display("FAIL x0_rs1: got %0d want %0d", rs1_sel, REG); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_stall: got %0b want 0", stall); end
    idle(4);
    drv(1'b1, 1, 0, 5, 1'b1, 1'b0, 1'b1, 1'b1);      // lw x5
    tick();
    drv(1'b0, 5, 5, 6, 1'b1, 1'b1, 1'b1, 1'b0);      // id_valid low over a hazard
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL novalid_stall: got %0b want 0", stall); end
    idle(4);
  endtask

  task automatic test_flush_and_hold();
    drv(1'b1, 1, 0, 5, 1'b1, 1'b0, 1'b1, 1'b1);      // lw x5
    tick();
    drv(1'b1, 5, 0, 6, 1'b1, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %0b want 0", stall); end
    tick();
    drv(1'b1, 5, 0, 6, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (dut.sb_q[0].vld !== 1'b0) begin bad++; $display("FAIL flush_bubble: got %0b want 0", dut.sb_q[0].vld); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_dist2: got %0b want 1", stall); end
    pipe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL hold_stall[%0d]: got %0b want 1", i, stall); end
      total++; if (rs1_sel2 !== EXE) begin bad++; $display("FAIL hold_sel2[%0d]: got %0d want %0d", i, rs1_sel2, EXE); end
    end
    pipe_ready = 1'b1;
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL hold_release: got %0b want 0", stall); end
    total++; if (rs1_sel !== MEM) begin bad++; $display("FAIL hold_mem: got %0d want %0d", rs1_sel, MEM); end
    idle(4);
  endtask

  task automatic test_reset_mid_stall();
    drv(1'b1, 1, 0, 5, 1'b1, 1'b0, 1'b1, 1'b1);      // lw x5
    tick();
    drv(1'b1, 5, 5, 6, 1'b1, 1'b1, 1'b1, 1'b0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rms_pre: got %0b want 1", stall); end
    tick();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rms_stall: got %0b want 0", stall); end
    total++; if (rs1_sel !== REG) begin bad++; $display("FAIL rms_rs1: got %0d want %0d", rs1_sel, REG); end
    total++; if (rs2_sel !== REG) begin bad++; $display("FAIL rms_rs2: got %0d want %0d", rs2_sel, REG); end
    idle(4);
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    aresetn = 1'b0;
    idle(1);
    aresetn = 1'b1;
    drv(1'b1, 1, 0, 5, 1'b1, 1'b0, 1'b1, 1'b1); tick();   // lw x5
    drv(1'b1, 5, 0, 8, 1'b1, 1'b0, 1'b1, 1'b0);            // 2 stalls + MEM fwd
    tick(); tick(); tick();
    drv(1'b1, 1, 0, 6, 1'b1, 1'b0, 1'b1, 1'b1); tick();   // lw x6
    drv(1'b1, 6, 0, 9, 1'b1, 1'b0, 1'b1, 1'b0);            // 2 stalls + MEM fwd
    tick(); tick(); tick();
    drv(1'b1, 0, 0, 7, 1'b1, 1'b0, 1'b1, 1'b0); tick();   // addi x7
    drv(1'b1, 7, 0, 10, 1'b1, 1'b0, 1'b1, 1'b0); tick();  // ALU fwd
    idle(1);
    total++; if (stall_cycles !== 32'd4) begin bad++; $display("FAIL stats_stalls: got %0d want 4", stall_cycles); end
    total++; if (fwd_events !== 32'd3) begin bad++; $display("FAIL stats_fwd: got %0d want 3", fwd_events); end
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL stats_rst_stalls: got %0d want 0", stall_cycles); end
    total++; if (fwd_events !== 32'd0) begin bad++; $display("FAIL stats_rst_fwd: got %0d want 0", fwd_events); end
  endtask
`endif

  initial begin
    aresetn = 1'b0;
    pipe_ready = 1'b1;
    flush = 1'b0;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_reorder();
    test_x0_and_invalid();
    test_flush_and_hold();
    test_reset_mid_stall();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
